// File: rtl/game_pkg.sv
// Shared constants, state encoding and X-position folding for the meteor spawner.
package game_pkg;

    localparam int SCREEN_W    = 640;
    localparam int METEOR_W    = 32;
    localparam int MAX_METEORS = 8;
    localparam int X_MAX       = SCREEN_W - METEOR_W;   // 608: rightmost legal left edge

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PICK_X = 3'd2,
        ST_PICK_S = 3'd3,
        ST_OFFER  = 3'd4
    } spawner_state_t;

    // Map a raw random value onto the playfield. Values past X_MAX are
    // shifted down rather than clamped so the far edge is not over-weighted.
    function automatic logic [9:0] fold_x(input logic [15:0] raw);
        return (raw <= 16'(X_MAX)) ? 10'(raw) : 10'(raw - 16'(X_MAX) - 16'd1);
    endfunction

endpackage

// File: rtl/meteor_spawner.sv
// Turns frame ticks and the free-running LFSR stream into meteor spawn
// requests on a valid/ready handshake, tracking live meteors against capacity
// and shortening the spawn interval every eighth accepted spawn.
module meteor_spawner
    import game_pkg::*;
#(
    parameter int RAND_W       = 10,
    parameter int SPAWN_PERIOD = 60,
    parameter int MIN_PERIOD   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [RAND_W-1:0] rand_in,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [9:0]        spawn_x,
    output logic [2:0]        spawn_speed,
    input  logic              retire,
    output logic [3:0]        active_count,
    output logic [7:0]        period
);

    spawner_state_t r_state;
    spawner_state_t w_state_next;

    logic [7:0] r_timer;
    logic [7:0] r_period;
    logic [2:0] r_spawn_count;
    logic [3:0] r_active;
    logic [9:0] r_x;
    logic [2:0] r_speed;
    logic       r_valid;

    logic       w_expired;
    logic       w_has_room;
    logic       w_accept;
    logic       w_retire_ok;
    logic       w_load_x;
    logic       w_load_s;
    logic [7:0] w_period_upd;

    // Timer runs out either on the tick that takes it from 1 to 0 or when it already sits at 0
    assign w_expired  = (r_timer == 8'd0) || (frame_tick && (r_timer == 8'd1));
    assign w_has_room = (r_active < 4'(MAX_METEORS));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; dropping enable wins from every state
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_WAIT;
                ST_WAIT:   if (w_expired && w_has_room) w_state_next = ST_PICK_X;
                ST_PICK_X: w_state_next = ST_PICK_S;
                ST_PICK_S: w_state_next = ST_OFFER;
                ST_OFFER:  if (spawn_ready) w_state_next = ST_WAIT;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Per-state control strobes and the post-accept period value.
    // A transfer is honoured whenever valid and ready meet on an edge, even if
    // enable falls on that same edge, since the table has already taken it.
    always_comb begin
        w_accept     = (r_state == ST_OFFER) && spawn_ready;
        w_retire_ok  = retire && (r_active != 4'd0);
        w_load_x     = (r_state == ST_PICK_X) && enable;
        w_load_s     = (r_state == ST_PICK_S) && enable;
        w_period_upd = r_period;
        if (r_spawn_count == 3'd7) begin
            if ({1'b0, r_period} >= 9'(MIN_PERIOD + 4)) begin
                w_period_upd = r_period - 8'd4;
            end else begin
                w_period_upd = 8'(MIN_PERIOD);
            end
        end
    end

    // Datapath: timer, captured spawn parameters, counters and registered valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer       <= 8'd0;
            r_period      <= 8'(SPAWN_PERIOD);
            r_spawn_count <= 3'd0;
            r_active      <= 4'd0;
            r_x           <= 10'd0;
            r_speed       <= 3'd0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= (w_state_next == ST_OFFER);

            if ((r_state == ST_IDLE) && enable) begin
                r_timer <= r_period;
            end else if (w_accept) begin
                r_timer <= w_period_upd;
            end else if ((r_state == ST_WAIT) && frame_tick && (r_timer != 8'd0)) begin
                r_timer <= r_timer - 8'd1;
            end

            if (w_load_x) begin
                r_x <= fold_x(16'(rand_in));
            end
            if (w_load_s) begin
                r_speed <= {1'b0, rand_in[2:1]} + 3'd1;
            end

            if (w_accept) begin
                r_spawn_count <= r_spawn_count + 3'd1;
                r_period      <= w_period_upd;
            end

            // An accept and a retire on the same edge cancel out
            case ({w_accept, w_retire_ok})
                2'b10:   r_active <= r_active + 4'd1;
                2'b01:   r_active <= r_active - 4'd1;
                default: r_active <= r_active;
            endcase
        end
    end

    assign spawn_valid  = r_valid;
    assign spawn_x      = r_x;
    assign spawn_speed  = r_speed;
    assign active_count = r_active;
    assign period       = r_period;

endmodule

// File: tb/tb_meteor_spawner.sv
// Directed bench for meteor_spawner with a short spawn period (4, floor 2).
module tb_meteor_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [9:0] rand_in;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [9:0] spawn_x;
    logic [2:0] spawn_speed;
    logic       retire;
    logic [3:0] active_count;
    logic [7:0] period;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count;
    int exp_period;
    int acc_total;

    typedef struct {
        logic [9:0] x_raw;
        logic [9:0] s_raw;
        logic [9:0] exp_x;
        logic [2:0] exp_s;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    meteor_spawner #(
        .RAND_W      (10),
        .SPAWN_PERIOD(4),
        .MIN_PERIOD  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .rand_in     (rand_in),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_x     (spawn_x),
        .spawn_speed (spawn_speed),
        .retire      (retire),
        .active_count(active_count),
        .period      (period)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic give_ticks(input int n, input logic [9:0] xr);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            rand_in    = xr;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    // n ticks, X value presented through the PICK_X edge, speed value on the next
    task automatic issue_spawn(input int n, input logic [9:0] xr, input logic [9:0] sr);
        give_ticks(n, xr);
        check("valid_not_early", 32'(spawn_valid), 32'd0);
        rand_in = sr;
        step();
        rand_in = 10'd0;
        check("valid_raised", 32'(spawn_valid), 32'd1);
    endtask

    task automatic finish_accept(input logic rt);
        spawn_ready = 1'b1;
        retire      = rt;
        step();
        spawn_ready = 1'b0;
        retire      = 1'b0;
        acc_total++;
        if (!rt) exp_count++;
        if (acc_total % 8 == 0) exp_period = (exp_period >= 6) ? exp_period - 4 : 2;
        check("valid_after_accept", 32'(spawn_valid), 32'd0);
        check("count_after_accept", 32'(active_count), 32'(exp_count));
        check("period_after_accept", 32'(period), 32'(exp_period));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},  32'(spawn_valid),  32'd0);
        check({tag, "_x"},      32'(spawn_x),      32'd0);
        check({tag, "_speed"},  32'(spawn_speed),  32'd0);
        check({tag, "_count"},  32'(active_count), 32'd0);
        check({tag, "_period"}, 32'(period),       32'd4);
    endtask

    initial begin
        int seen;

        vecs[0] = '{x_raw: 10'd100,  s_raw: 10'd5, exp_x: 10'd100, exp_s: 3'd3};
        vecs[1] = '{x_raw: 10'd700,  s_raw: 10'd0, exp_x: 10'd91,  exp_s: 3'd1};
        vecs[2] = '{x_raw: 10'd608,  s_raw: 10'd6, exp_x: 10'd608, exp_s: 3'd4};
        vecs[3] = '{x_raw: 10'd609,  s_raw: 10'd2, exp_x: 10'd0,   exp_s: 3'd2};
        vecs[4] = '{x_raw: 10'd1023, s_raw: 10'd3, exp_x: 10'd414, exp_s: 3'd2};

        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; rand_in = 10'd0;
        spawn_ready = 1'b0; retire = 1'b0;
        exp_count = 0; exp_period = 4; acc_total = 0;
        step(); step();
        check_reset_values("reset");
        reset = 1'b0;
        enable = 1'b1;
        step();

        // Table of X folding and speed extraction, ready asserted at OFFER
        for (int v = 0; v < 5; v++) begin
            issue_spawn(exp_period, vecs[v].x_raw, vecs[v].s_raw);
            check($sformatf("vec%0d_x", v),     32'(spawn_x),     32'(vecs[v].exp_x));
            check($sformatf("vec%0d_speed", v), 32'(spawn_speed), 32'(vecs[v].exp_s));
            finish_accept(1'b0);
        end

        // Backpressure: request held stable for 10 cycles, then accepted once
        issue_spawn(exp_period, 10'd200, 10'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold", {18'd0, spawn_valid, spawn_x, spawn_speed}, {18'd0, 1'b1, 10'd200, 3'd1});
        end
        finish_accept(1'b0);
        step();
        check("stall_single_accept", 32'(active_count), 32'(exp_count));

        // Two more spawns reach capacity; the 8th accept drops period 4 -> 2
        for (int i = 0; i < 2; i++) begin
            issue_spawn(exp_period, 10'd64, 10'd0);
            finish_accept(1'b0);
        end
        check("full_count", 32'(active_count), 32'd8);
        check("period_dropped", 32'(period), 32'd2);

        // At capacity the timer expires without a request
        give_ticks(exp_period, 10'd50);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (spawn_valid) seen++;
        end
        check("full_no_valid", 32'(seen), 32'd0);

        // Retire frees a slot; the spawn then proceeds
        rand_in = 10'd50;
        retire  = 1'b1;
        step();
        retire  = 1'b0;
        exp_count--;
        check("retire_count", 32'(active_count), 32'(exp_count));
        step();
        step();
        rand_in = 10'd4;
        step();
        rand_in = 10'd0;
        check("refill_valid", 32'(spawn_valid), 32'd1);
        check("refill_x",     32'(spawn_x),     32'd50);
        check("refill_speed", 32'(spawn_speed), 32'd3);
        finish_accept(1'b0);

        // Lone retire, then retire coinciding with an accept
        retire = 1'b1;
        step();
        retire = 1'b0;
        exp_count--;
        check("lone_retire", 32'(active_count), 32'(exp_count));
        issue_spawn(exp_period, 10'd10, 10'd7);
        check("coincide_x",     32'(spawn_x),     32'd10);
        check("coincide_speed", 32'(spawn_speed), 32'd4);
        finish_accept(1'b1);

        // 16 further spawns keep the period at its floor
        for (int i = 0; i < 16; i++) begin
            issue_spawn(exp_period, 10'(i * 30), 10'(i));
            check($sformatf("floor%0d_x", i),     32'(spawn_x),     32'(i * 30));
            check($sformatf("floor%0d_speed", i), 32'(spawn_speed), 32'(((i >> 1) & 3) + 1));
            finish_accept(1'b1);
        end
        check("period_floor", 32'(period), 32'd2);

        // Enable dropped during OFFER discards the request
        issue_spawn(exp_period, 10'd300, 10'd0);
        enable = 1'b0;
        step();
        check("disable_valid",  32'(spawn_valid),  32'd0);
        check("disable_count",  32'(active_count), 32'(exp_count));
        check("disable_period", 32'(period),       32'(exp_period));
        spawn_ready = 1'b1;
        step();
        step();
        spawn_ready = 1'b0;
        check("disable_no_transfer", {31'd0, spawn_valid, 28'd0, active_count} == {31'd0, 1'b0, 28'd0, 4'(exp_count)} ? 32'd1 : 32'd0, 32'd1);
        enable = 1'b1;
        step();
        issue_spawn(exp_period, 10'd320, 10'd2);
        check("resume_x", 32'(spawn_x), 32'd320);
        finish_accept(1'b0);

        // Reset in the middle of WAIT restores every output
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        reset = 1'b1;
        step();
        check_reset_values("midwait_reset");
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
